// File: rtl/char_buffer_arbiter.sv
// Keyboard-driven text line controller sharing a single-port character RAM with the display fetch.
// Display reads always win the port; keyboard edits wait in a 1-deep pending slot or the clear sweep.
module char_buffer_arbiter #(
  parameter int             COLS  = 16,
  parameter int             CW    = 4,
  parameter int             DW    = 6,
  parameter logic [DW-1:0]  BLANK = 6'd0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          kbd_flag,
  input  logic [7:0]    kbd_code,
  input  logic [DW-1:0] char_addr,
  input  logic          rd_req,
  input  logic [CW-1:0] rd_col,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          ram_en,
  output logic          ram_we,
  output logic [CW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          clr_ovf,
  output logic [CW-1:0] cursor,
  output logic          busy,
  output logic          overflow
);

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BKSP  = 8'h66;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic {F_MAKE, F_BREAK} filt_t;
  typedef enum logic {C_IDLE, C_CLEAR} clr_t;

  filt_t         filt_q, filt_d;
  clr_t          clr_q, clr_d;
  logic          pend_valid_q, pend_valid_d;
  logic [CW-1:0] pend_addr_q, pend_addr_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          ovf_q, ovf_d;
  logic          rd_valid_q;
  logic [DW-1:0] rd_hold_q;
  logic          busy_w;
  logic          action;

  assign busy_w = pend_valid_q | (clr_q == C_CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q       <= F_MAKE;
      clr_q        <= C_IDLE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      cursor_q     <= '0;
      idx_q        <= '0;
      ovf_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_hold_q    <= '0;
    end else begin
      filt_q       <= filt_d;
      clr_q        <= clr_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      cursor_q     <= cursor_d;
      idx_q        <= idx_d;
      ovf_q        <= ovf_d;
      rd_valid_q   <= rd_req;
      if (rd_valid_q)
        rd_hold_q <= ram_rdata;
    end
  end

  // Port arbitration first, then the filter; an accepted action never coincides with a grant.
  always_comb begin
    filt_d       = filt_q;
    clr_d        = clr_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    cursor_d     = cursor_q;
    idx_d        = idx_q;
    ovf_d        = ovf_q;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = rd_col;
    ram_wdata    = BLANK;
    action       = 1'b0;

    if (rd_req) begin
      ram_en = 1'b1;
    end else if (pend_valid_q) begin
      ram_en       = 1'b1;
      ram_we       = 1'b1;
      ram_addr     = pend_addr_q;
      ram_wdata    = pend_data_q;
      pend_valid_d = 1'b0;
    end else if (clr_q == C_CLEAR) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = idx_q;
      ram_wdata = BLANK;
      idx_d     = idx_q + 1'b1;
      if (idx_q == LAST_COL)
        clr_d = C_IDLE;
    end

    if (kbd_flag) begin
      case (filt_q)
        F_MAKE: begin
          if (kbd_code == CODE_BREAK)
            filt_d = F_BREAK;
          else if (kbd_code != CODE_EXT)
            action = 1'b1;
        end
        default: filt_d = F_MAKE;
      endcase
    end

    if (action && !busy_w) begin
      case (kbd_code)
        CODE_BKSP: begin
          if (cursor_q != '0) begin
            cursor_d     = cursor_q - 1'b1;
            pend_valid_d = 1'b1;
            pend_addr_d  = cursor_q - 1'b1;
            pend_data_d  = BLANK;
          end
        end
        CODE_ENTER: begin
          clr_d    = C_CLEAR;
          idx_d    = '0;
          cursor_d = '0;
        end
        default: begin
          pend_valid_d = 1'b1;
          pend_addr_d  = cursor_q;
          pend_data_d  = char_addr;
          cursor_d     = cursor_q + 1'b1;
        end
      endcase
    end

    // A drop in the same cycle as clr_ovf keeps the flag set.
    if (action && busy_w)
      ovf_d = 1'b1;
    else if (clr_ovf)
      ovf_d = 1'b0;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? ram_rdata : rd_hold_q;
  assign cursor   = cursor_q;
  assign busy     = busy_w;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// Cycle-by-cycle check of char_buffer_arbiter against a queue-based model of the line editor,
// with a behavioural single-port RAM attached to the DUT's port.
module tb_char_buffer_arbiter;

  typedef struct packed {
    logic [3:0] addr;
    logic [5:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       kbd_flag = 1'b0;
  logic [7:0] kbd_code = 8'h00;
  logic [5:0] char_addr = 6'd0;
  logic       rd_req = 1'b0;
  logic [3:0] rd_col = 4'd0;
  logic [5:0] rd_data;
  logic       rd_valid;
  logic       ram_en;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [5:0] ram_wdata;
  logic [5:0] ram_rdata = 6'd0;
  logic       clr_ovf = 1'b0;
  logic [3:0] cursor;
  logic       busy;
  logic       overflow;

  logic [5:0] mem [16];

  int tests_run = 0;
  int tests_failed = 0;

  wr_t        m_q[$];
  logic [5:0] m_mem [16];
  int         m_cursor;
  bit         m_break;
  bit         m_ovf;
  bit         m_rdv;
  logic [5:0] m_rdval;
  logic [5:0] m_rdlast;

  char_buffer_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .kbd_flag (kbd_flag),
    .kbd_code (kbd_code),
    .char_addr(char_addr),
    .rd_req   (rd_req),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .clr_ovf  (clr_ovf),
    .cursor   (cursor),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we)
        mem[ram_addr] <= ram_wdata;
      else
        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_cursor = 0;
    m_break  = 0;
    m_ovf    = 0;
    m_rdv    = 0;
    m_rdlast = 6'd0;
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic applyStimulus(input bit kf, input logic [7:0] code, input logic [5:0] ca,
                               input bit rr, input logic [3:0] rc, input bit co);
    bit  exp_busy;
    bit  act;
    wr_t w;
    @(negedge clk);
    kbd_flag  = kf;
    kbd_code  = code;
    char_addr = ca;
    rd_req    = rr;
    rd_col    = rc;
    clr_ovf   = co;
    #1;
    exp_busy = (m_q.size() != 0);
    checkOutput("busy", 32'(busy), 32'(exp_busy));
    checkOutput("cursor", 32'(cursor), 32'(m_cursor));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("rd_valid", 32'(rd_valid), 32'(m_rdv));
    checkOutput("rd_data", 32'(rd_data), 32'(m_rdv ? m_rdval : m_rdlast));
    if (rr) begin
      checkOutput("rd_en", 32'(ram_en), 32'd1);
      checkOutput("rd_we", 32'(ram_we), 32'd0);
      checkOutput("rd_addr", 32'(ram_addr), 32'(rc));
    end else if (exp_busy) begin
      checkOutput("wr_en", 32'(ram_en), 32'd1);
      checkOutput("wr_we", 32'(ram_we), 32'd1);
      checkOutput("wr_addr", 32'(ram_addr), 32'(m_q[0].addr));
      checkOutput("wr_data", 32'(ram_wdata), 32'(m_q[0].data));
    end else begin
      checkOutput("idle_en", 32'(ram_en), 32'd0);
      checkOutput("idle_we", 32'(ram_we), 32'd0);
    end

    if (m_rdv)
      m_rdlast = m_rdval;
    if (rr) begin
      m_rdval = m_mem[rc];
    end else if (exp_busy) begin
      w = m_q.pop_front();
      m_mem[w.addr] = w.data;
    end
    m_rdv = rr;

    act = 0;
    if (kf) begin
      if (m_break)
        m_break = 0;
      else if (code == 8'hF0)
        m_break = 1;
      else if (code != 8'hE0)
        act = 1;
    end
    if (act && !exp_busy) begin
      if (code == 8'h66) begin
        if (m_cursor != 0) begin
          m_cursor = m_cursor - 1;
          m_q.push_back('{addr: 4'(m_cursor), data: 6'd0});
        end
      end else if (code == 8'h5A) begin
        m_cursor = 0;
        for (int i = 0; i < 16; i++)
          m_q.push_back('{addr: 4'(i), data: 6'd0});
      end else begin
        m_q.push_back('{addr: 4'(m_cursor), data: ca});
        m_cursor = (m_cursor + 1) % 16;
      end
    end
    if (act && exp_busy)
      m_ovf = 1;
    else if (co)
      m_ovf = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 8'h00, 6'd0, 0, 4'd0, 0);
  endtask

  task automatic key(input logic [7:0] code, input logic [5:0] ca);
    applyStimulus(1, code, ca, 0, 4'd0, 0);
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge sees it.
  task automatic doReset();
    @(negedge clk);
    kbd_flag = 0;
    rd_req   = 0;
    clr_ovf  = 0;
    reset    = 0;
    #1;
    checkOutput("rst_cursor", 32'(cursor), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_en", 32'(ram_en), 32'd0);
    checkOutput("rst_we", 32'(ram_we), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_rdv", 32'(rd_valid), 32'd0);
    modelReset();
    @(posedge clk);
    #2;
    reset = 1;
  endtask

  initial begin
    bit         rr_burst;
    bit         kf;
    logic [7:0] code;
    int         sel;
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 6'(i + 32);
      m_mem[i] = 6'(i + 32);
    end
    modelReset();
    m_rdval = 6'd0;
    repeat (2) @(posedge clk);
    doReset();
    idle(2);

    key(8'h1C, 6'd10);
    idle(3);

    key(8'h1C, 6'd11); idle(3);
    key(8'hF0, 6'd0);  idle(3);
    key(8'h1C, 6'd11); idle(4);

    key(8'h2A, 6'd21);
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 8'h00, 6'd0, 1, 4'(i), 0);
    idle(3);

    key(8'h5A, 6'd0);
    idle(5);
    doReset();
    key(8'h1C, 6'd33);
    idle(2);

    key(8'h5A, 6'd0);
    idle(18);
    for (int i = 0; i < 16; i++) begin
      key(8'h30, 6'(i + 1));
      idle(1);
    end
    key(8'h66, 6'd0);
    idle(2);
    key(8'h30, 6'd50);
    idle(2);
    key(8'h66, 6'd0);
    idle(2);
    key(8'hE0, 6'd0);
    idle(1);

    key(8'h5A, 6'd0);
    idle(2);
    key(8'h1C, 6'd7);
    idle(20);
    applyStimulus(0, 8'h00, 6'd0, 0, 4'd0, 1);
    idle(2);

    rr_burst = 0;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 7) == 0)
        rr_burst = ~rr_burst;
      kf  = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 19);
      case (sel)
        0, 1:    code = 8'hF0;
        2:       code = 8'hE0;
        3, 4:    code = 8'h66;
        5:       code = 8'h5A;
        default: code = 8'($urandom_range(0, 255));
      endcase
      applyStimulus(kf, code, 6'($urandom_range(0, 63)), rr_burst,
                    4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
    end
    idle(20);

    for (int i = 0; i < 16; i++)
      checkOutput("ram_contents", 32'(mem[i]), 32'(m_mem[i]));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/char_buffer_arbiter.md
Name: char_buffer_arbiter

Overview:
- Controls the on-screen text line built from PS/2 keystrokes.
- Filters raw scancodes into make-events, maintains a cursor, and turns each event into writes to a single-port character RAM: print, backspace, or clear-line.
- Shares that RAM port with the VGA character-fetch path. Display reads always win; keyboard writes wait in a 1-deep pending slot.
- Runs on the pixel clock (clkdiv4), between the keyboard protocol/decoder and the ROM address generation.

Parameters:
- COLS, 16: number of character cells in the line buffer; must be a power of 2.
- CW, 4: cursor/column address width; equals log2(COLS).
- DW, 6: character (glyph start address) width.
- BLANK, 6'd0: glyph code written for an empty cell.

Ports:
- clk  in  1  pixel clock (clkdiv4).
- reset  in  1  asynchronous, active-low reset.
- kbd_flag  in  1  one-cycle pulse; kbd_code and char_addr are valid.
- kbd_code  in  8  raw PS/2 scancode byte.
- char_addr  in  DW  decoded glyph start address for kbd_code.
- rd_req  in  1  display fetch request, level per cycle.
- rd_col  in  CW  column to fetch.
- rd_data  out  DW  fetched glyph code.
- rd_valid  out  1  rd_data valid.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  CW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, 1-cycle latency after ram_en & !ram_we.
- clr_ovf  in  1  synchronous clear of the overflow flag.
- cursor  out  CW  current write column.
- busy  out  1  write pending or clear in progress.
- overflow  out  1  sticky: a keyboard action was dropped.

Behaviour:
- Reset (reset=0, async): all registers cleared.
  - Outputs: cursor=0, busy=0, overflow=0, rd_valid=0, ram_en=0, ram_we=0.
  - Filter returns to F_MAKE; pending slot is emptied; clear FSM returns to IDLE.
  - RAM contents are not touched by reset.
- Scancode filter FSM (evaluated only on kbd_flag):
  - F_MAKE, code 0xF0 -> F_BREAK, no action.
  - F_MAKE, code 0xE0 -> stay in F_MAKE, no action.
  - F_MAKE, any other code -> generate an action, stay in F_MAKE.
  - F_BREAK, any code -> F_MAKE, no action (release ignored).
  - The filter keeps running during clear and while a write is pending.
- Action mapping:
  - 0x66: BACKSPACE.
  - 0x5A: CLEAR.
  - Otherwise: PRINT(char_addr).
- Action acceptance:
  - Accepted only when busy=0.
  - If busy=1, the action is dropped and overflow is set on the next edge.
  - If clr_ovf and a drop occur in the same cycle, set wins.
- PRINT:
  - Loads pending write {addr=cursor, data=char_addr}.
  - cursor <= cursor+1, wrapping COLS-1 -> 0.
- BACKSPACE:
  - If cursor=0: no write, no change.
  - Otherwise: cursor <= cursor-1 and pending write {addr=cursor-1, data=BLANK}.
- CLEAR:
  - Enters C_CLEAR with idx=0 and sets cursor=0.
  - Writes BLANK to idx 0..COLS-1 in order; idx advances only on cycles where the write is granted.
  - Returns to IDLE after idx COLS-1 is written.
- busy = pending valid OR state==C_CLEAR. busy is registered and rises the cycle after acceptance.
- RAM port arbitration, one operation per cycle, priority order:
  1. rd_req=1: ram_en=1, ram_we=0, ram_addr=rd_col.
  2. Else, pending write or C_CLEAR: ram_en=1, ram_we=1, address/data from the pending slot or the clear index. The pending slot empties on grant.
  3. Else: ram_en=0.
- RAM port outputs are combinational from the current state and rd_req.
- Read latency:
  - rd_valid is rd_req delayed one cycle.
  - rd_data = ram_rdata while rd_valid=1; held at the last value otherwise.
  - Back-to-back rd_req gives one rd_valid per cycle.
- Starvation: continuous rd_req stalls writes indefinitely. The display releases the port during blanking.
- Simultaneous write grant and new kbd_flag:
  - The new action is accepted only if busy=0 at that edge.
  - busy is still 1 during the grant cycle, so the action is dropped.

Test Plan:
- Reset mid-clear (reset low with idx=5) -> cursor=0, busy=0, ram_en=0 immediately; a later PRINT writes address 0.
- kbd_flag with code 0x1C, char_addr=6'd10, rd_req=0 -> next cycle ram_we=1, ram_addr=0, ram_wdata=10; cursor=1; busy falls after the grant.
- Sequence 0x1C, 0xF0, 0x1C spaced 4 cycles apart -> exactly one write; cursor=1; filter back in F_MAKE.
- rd_req held high for 20 cycles with a PRINT pending -> no ram_we during the hold; write issued the first cycle rd_req=0; rd_valid high for 20 cycles, each one cycle after its request.
- 16 PRINTs then one more -> cursor wraps 15 -> 0 and the 17th write hits address 0; BACKSPACE at cursor=0 -> no write.
- CLEAR (0x5A) followed by a PRINT 3 cycles later -> 16 BLANK writes to addresses 0..15; the PRINT is dropped; overflow=1 until clr_ovf pulses.
